// File: rtl/intr_pkg.sv
// Shared constants, FSM state type and helpers for the vectored interrupt arbiter.
package intr_pkg;

  localparam int unsigned VEC_W = 9;
  localparam int unsigned PTR_W = 3;
  localparam int unsigned LVL5  = 1;
  localparam int unsigned LVL4  = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Index of the set bit in a one-hot grant (up to 8 devices per level).
  function automatic logic [PTR_W-1:0] onehot_idx(input logic [7:0] oh);
    onehot_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) onehot_idx = PTR_W'(i);
    end
  endfunction

endpackage

// File: rtl/intr_level_sel.sv
// Per-level winner select: fixed priority (index 0 highest), or round robin
// starting after the last-grant pointer when INTR_ROUND_ROBIN_EN is defined.
module intr_level_sel
  import intr_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  // Lowest set bit as one-hot; descending scan so the lowest index wins.
  function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
    lowest = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest    = '0;
        lowest[i] = 1'b1;
      end
    end
  endfunction

`ifdef INTR_ROUND_ROBIN_EN
  logic [N-1:0] upper;

  // Requests above the pointer are searched first, then the wrap to index 0.
  always_comb begin
    upper = '0;
    for (int i = 0; i < int'(N); i++) begin
      upper[i] = req[i] && (i > int'(ptr));
    end
  end

  assign grant = (|upper) ? lowest(upper) : lowest(req);
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign grant      = lowest(req);
`endif

  assign valid = |req;

endmodule

// File: rtl/intr_arbiter.sv
// Vectored interrupt arbiter for bus levels 5 and 4 with strobe/ack handshake.
// Optional round-robin selection per level: define INTR_ROUND_ROBIN_EN.
module intr_arbiter
  import intr_pkg::*;
#(
  parameter int unsigned      N5          = 4,
  parameter int unsigned      N4          = 8,
  parameter logic [VEC_W-1:0] PASSIVE_VEC = 9'o000
) (
  input  logic                clk_p,
  input  logic                bus_reset,
  input  logic [N5-1:0]       dev_irq5,
  input  logic [VEC_W*N5-1:0] dev_vec5,
  output logic [N5-1:0]       dev_iack5,
  input  logic [N4-1:0]       dev_irq4,
  input  logic [VEC_W*N4-1:0] dev_vec4,
  output logic [N4-1:0]       dev_iack4,
  output logic [1:0]          irq_o,
  input  logic [1:0]          istb_i,
  output logic [VEC_W-1:0]    ivec_o,
  output logic                iack_o
);

  state_t           state;
  logic             lvl5_q;
  logic [PTR_W-1:0] ptr5;
  logic [PTR_W-1:0] ptr4;
  logic [N5-1:0]    gnt5;
  logic [N4-1:0]    gnt4;
  logic             val5;
  logic             val4;
  logic [VEC_W-1:0] vec5;
  logic [VEC_W-1:0] vec4;
  logic [VEC_W-1:0] sel_vec;
  logic             sel_valid;

  intr_level_sel #(.N(N5)) u_sel5 (
    .req   (dev_irq5),
    .ptr   (ptr5),
    .grant (gnt5),
    .valid (val5)
  );

  intr_level_sel #(.N(N4)) u_sel4 (
    .req   (dev_irq4),
    .ptr   (ptr4),
    .grant (gnt4),
    .valid (val4)
  );

  // Vector of the one-hot winner at each level, then the latched level's pick.
  always_comb begin
    vec5 = '0;
    vec4 = '0;
    for (int i = 0; i < int'(N5); i++) begin
      if (gnt5[i]) vec5 = dev_vec5[i*VEC_W +: VEC_W];
    end
    for (int i = 0; i < int'(N4); i++) begin
      if (gnt4[i]) vec4 = dev_vec4[i*VEC_W +: VEC_W];
    end
    sel_vec   = lvl5_q ? vec5 : vec4;
    sel_valid = lvl5_q ? val5 : val4;
  end

`ifndef INTR_ROUND_ROBIN_EN
  assign ptr5 = '0;
  assign ptr4 = '0;
`endif

  always_ff @(posedge clk_p) begin
    if (bus_reset) begin
      state     <= IDLE;
      lvl5_q    <= 1'b0;
      irq_o     <= '0;
      ivec_o    <= '0;
      iack_o    <= 1'b0;
      dev_iack5 <= '0;
      dev_iack4 <= '0;
`ifdef INTR_ROUND_ROBIN_EN
      ptr5      <= PTR_W'(N5 - 1);
      ptr4      <= PTR_W'(N4 - 1);
`endif
    end else begin
      irq_o[LVL5] <= |dev_irq5;
      irq_o[LVL4] <= |dev_irq4;
      case (state)
        IDLE: begin
          if (|istb_i) begin
            lvl5_q <= istb_i[LVL5];
            state  <= GRANT;
          end
        end
        // Winner is frozen here; later requests cannot change it.
        GRANT: begin
          iack_o    <= 1'b1;
          ivec_o    <= sel_valid ? sel_vec : PASSIVE_VEC;
          dev_iack5 <= lvl5_q ? gnt5 : '0;
          dev_iack4 <= lvl5_q ? '0 : gnt4;
`ifdef INTR_ROUND_ROBIN_EN
          if (lvl5_q && val5) ptr5 <= onehot_idx(8'(gnt5));
          if (!lvl5_q && val4) ptr4 <= onehot_idx(8'(gnt4));
`endif
          state     <= ACK;
        end
        ACK: begin
          iack_o    <= 1'b0;
          dev_iack5 <= '0;
          dev_iack4 <= '0;
          state     <= RELEASE;
        end
        RELEASE: begin
          if (istb_i == 2'b00) begin
            ivec_o <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed self-checking bench for intr_arbiter.
module tb_intr_arbiter;
  import intr_pkg::*;

  localparam int unsigned    N5   = 4;
  localparam int unsigned    N4   = 8;
  localparam logic [8:0]     PVEC = 9'o777;

  logic              clk_p = 1'b0;
  logic              bus_reset;
  logic [N5-1:0]     dev_irq5;
  logic [9*N5-1:0]   dev_vec5;
  logic [N5-1:0]     dev_iack5;
  logic [N4-1:0]     dev_irq4;
  logic [9*N4-1:0]   dev_vec4;
  logic [N4-1:0]     dev_iack4;
  logic [1:0]        irq_o;
  logic [1:0]        istb_i;
  logic [8:0]        ivec_o;
  logic              iack_o;

  int errors = 0;
  int checks = 0;

  intr_arbiter #(.N5(N5), .N4(N4), .PASSIVE_VEC(PVEC)) dut (
    .clk_p     (clk_p),
    .bus_reset (bus_reset),
    .dev_irq5  (dev_irq5),
    .dev_vec5  (dev_vec5),
    .dev_iack5 (dev_iack5),
    .dev_irq4  (dev_irq4),
    .dev_vec4  (dev_vec4),
    .dev_iack4 (dev_iack4),
    .irq_o     (irq_o),
    .istb_i    (istb_i),
    .ivec_o    (ivec_o),
    .iack_o    (iack_o)
  );

  always #5 clk_p = ~clk_p;

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    int acks;
    logic [7:0] rr_exp [3];

    dev_vec5 = {9'o230, 9'o224, 9'o220, 9'o200};
    for (int k = 0; k < int'(N4); k++) dev_vec4[k*9 +: 9] = 9'o100 + 9'(k * 4);
    bus_reset = 1'b1;
    istb_i    = 2'b00;
    dev_irq5  = '0;
    dev_irq4  = '0;
    tick();
    tick();

    // Reset state
    check("rst_irq",   32'(irq_o),     32'h0);
    check("rst_ivec",  32'(ivec_o),    32'h0);
    check("rst_iack",  32'(iack_o),    32'h0);
    check("rst_diak5", 32'(dev_iack5), 32'h0);
    check("rst_diak4", 32'(dev_iack4), 32'h0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    bus_reset = 1'b0;
    tick();

    // Level-5: devices 1 and 2 request, device 1 wins
    dev_irq5 = 4'b0110;
    tick();
    check("l5_irq", 32'(irq_o), 32'h2);
    istb_i = 2'b10;
    tick();
    check("l5_iack_c1", 32'(iack_o), 32'h0);
    tick();
    check("l5_iack",  32'(iack_o),    32'h1);
    check("l5_ivec",  32'(ivec_o),    32'(9'o220));
    check("l5_diak5", 32'(dev_iack5), 32'h2);
    check("l5_diak4", 32'(dev_iack4), 32'h0);
    dev_irq5 = 4'b0100;
    istb_i   = 2'b00;
    tick();
    check("l5_iack_off", 32'(iack_o), 32'h0);
    check("l5_ivec_hold", 32'(ivec_o), 32'(9'o220));
    tick();
    check("l5_ivec_clr", 32'(ivec_o), 32'h0);
    check("l5_irq_rem",  32'(irq_o),  32'h2);
    dev_irq5 = '0;
    tick();

    // Both levels active and both strobes: level 5 device 0 served
    dev_irq5 = 4'b0001;
    dev_irq4 = 8'b0000_1000;
    tick();
    check("both_irq", 32'(irq_o), 32'h3);
    istb_i = 2'b11;
    tick();
    tick();
    check("both_ivec",  32'(ivec_o),    32'(9'o200));
    check("both_diak5", 32'(dev_iack5), 32'h1);
    check("both_diak4", 32'(dev_iack4), 32'h0);
    istb_i   = 2'b00;
    dev_irq5 = '0;
    tick();
    tick();

    // Level-4 request withdrawn before GRANT: passive vector
    istb_i = 2'b01;
    tick();
    dev_irq4 = '0;
    tick();
    check("wd_iack",  32'(iack_o),    32'h1);
    check("wd_ivec",  32'(ivec_o),    32'(PVEC));
    check("wd_diak4", 32'(dev_iack4), 32'h0);
    istb_i = 2'b00;
    tick();
    tick();

    // Held strobe: exactly one acknowledge, FSM parks in RELEASE
    dev_irq4 = 8'b0010_0000;
    istb_i   = 2'b01;
    pulses   = 0;
    acks     = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (iack_o === 1'b1) begin
        pulses++;
        check("held_ivec", 32'(ivec_o), 32'(9'o124));
      end
      if (dev_iack4[5] === 1'b1) begin
        acks++;
        dev_irq4 = '0;
      end
    end
    check("held_pulses", 32'(pulses),    32'd1);
    check("held_acks",   32'(acks),      32'd1);
    check("held_state",  32'(dut.state), 32'(RELEASE));
    check("held_irq",    32'(irq_o),     32'h0);
    istb_i = 2'b00;
    tick();
    check("held_idle", 32'(dut.state), 32'(IDLE));
    check("held_ivec_clr", 32'(ivec_o), 32'h0);

    // Reset during ACK, then a normal handshake
    dev_irq5 = 4'b1000;
    istb_i   = 2'b10;
    tick();
    tick();
    check("mid_iack", 32'(iack_o), 32'h1);
    bus_reset = 1'b1;
    tick();
    check("mid_rst_iack",  32'(iack_o),    32'h0);
    check("mid_rst_ivec",  32'(ivec_o),    32'h0);
    check("mid_rst_diak5", 32'(dev_iack5), 32'h0);
    check("mid_rst_irq",   32'(irq_o),     32'h0);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    bus_reset = 1'b0;
    istb_i    = 2'b00;
    tick();
    istb_i = 2'b10;
    tick();
    tick();
    check("post_iack",  32'(iack_o),    32'h1);
    check("post_ivec",  32'(ivec_o),    32'(9'o230));
    check("post_diak5", 32'(dev_iack5), 32'h8);
    istb_i   = 2'b00;
    dev_irq5 = '0;
    tick();
    tick();

    // All level-4 devices requesting across three strobes
`ifdef INTR_ROUND_ROBIN_EN
    rr_exp = '{8'h01, 8'h02, 8'h04};
`else
    rr_exp = '{8'h01, 8'h01, 8'h01};
`endif
    dev_irq4 = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      istb_i = 2'b01;
      tick();
      tick();
      check("rr_diak4", 32'(dev_iack4), 32'(rr_exp[k]));
      istb_i = 2'b00;
      tick();
      tick();
    end
    dev_irq4 = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
